// File: rtl/eq_gain_loader.sv
// Byte-stream to equalizer gain-RAM writer: NUM_GAINS 16-bit gains, LSB byte first; optional EQ_LOAD_TIMEOUT_EN.
// Latency: eq_wr 1 cycle after the MSB byte is taken; load_done 3 cycles after the last eq_wr.
// Backpressure: byte_rdy only in LSB/MSB; a byte offered while busy and not ready is dropped and flags load_err.
module eq_gain_loader #(
  parameter int NUM_GAINS      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_start,
  input  logic       byte_en,
  input  logic [7:0] cpu_byte,
  output logic       byte_rdy,
  output logic       eq_wr_rst,
  output logic       eq_wr,
  output logic [7:0] eq_gain_lsb,
  output logic [7:0] eq_gain_msb,
  input  logic       wr_addr_zero,
  output logic       busy,
  output logic       load_done,
  output logic       load_err,
  output logic [4:0] gain_count
);

  typedef enum logic [2:0] {IDLE, RST, LSB, MSB, WRITE, HOLD, CHECK, DONE} state_t;

  // A full 16-gain load wraps the 4-bit RAM address back to zero.
  localparam logic       ADDR_ZERO_EXP = (NUM_GAINS == 16);
  localparam logic [4:0] GAINS         = 5'(NUM_GAINS);

  if (NUM_GAINS < 1 || NUM_GAINS > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("eq_gain_loader: parameter out of range");
  end

  state_t state, state_nxt;
  logic   in_byte_state;
  logic   accept;
  logic   overrun;
  logic   timeout;

  assign in_byte_state = (state == LSB) || (state == MSB);
  assign accept        = byte_en && !load_start && in_byte_state;
  assign overrun       = byte_en && !load_start && !in_byte_state && (state != IDLE);

`ifdef EQ_LOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (load_start || accept || !in_byte_state) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  assign timeout = in_byte_state && !accept && !load_start &&
                   (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = RST;
    end else if (timeout) begin
      state_nxt = DONE;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RST:     state_nxt = LSB;
        LSB:     if (byte_en) state_nxt = MSB;
        MSB:     if (byte_en) state_nxt = WRITE;
        WRITE:   state_nxt = HOLD;
        HOLD:    state_nxt = (gain_count == GAINS) ? CHECK : LSB;
        CHECK:   state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so every one of them comes straight off a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_rdy    <= 1'b0;
      eq_wr_rst   <= 1'b0;
      eq_wr       <= 1'b0;
      eq_gain_lsb <= 8'h00;
      eq_gain_msb <= 8'h00;
      busy        <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      gain_count  <= 5'd0;
    end else begin
      byte_rdy  <= (state_nxt == LSB) || (state_nxt == MSB);
      eq_wr_rst <= (state_nxt == RST);
      eq_wr     <= (state_nxt == WRITE);
      busy      <= (state_nxt != IDLE);
      load_done <= (state_nxt == DONE);
      if (accept && state == LSB) eq_gain_lsb <= cpu_byte;
      if (accept && state == MSB) eq_gain_msb <= cpu_byte;
      if (load_start) begin
        gain_count <= 5'd0;
        load_err   <= 1'b0;
      end else begin
        if (state_nxt == WRITE) gain_count <= gain_count + 5'd1;
        if (overrun || timeout || (state == CHECK && wr_addr_zero != ADDR_ZERO_EXP))
          load_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eq_gain_loader.sv
// Bench for eq_gain_loader: a 4-gain and a 16-gain instance, each with a gain-stage address model.
module tb_eq_gain_loader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_start = 1'b0;
  logic       byte_en = 1'b0;
  logic [7:0] cpu_byte = 8'h00;

  logic       rdy4, wrst4, wr4, busy4, done4, err4, zero4;
  logic [7:0] lsb4, msb4;
  logic [4:0] cnt4;
  logic       rdy16, wrst16, wr16, busy16, done16, err16, zero16;
  logic [7:0] lsb16, msb16;
  logic [4:0] cnt16;

  always #5 clk = ~clk;

  eq_gain_loader #(.NUM_GAINS(4), .TIMEOUT_CYCLES(16)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .byte_en(byte_en),
    .cpu_byte(cpu_byte), .byte_rdy(rdy4), .eq_wr_rst(wrst4), .eq_wr(wr4),
    .eq_gain_lsb(lsb4), .eq_gain_msb(msb4), .wr_addr_zero(zero4), .busy(busy4),
    .load_done(done4), .load_err(err4), .gain_count(cnt4)
  );

  eq_gain_loader #(.NUM_GAINS(16), .TIMEOUT_CYCLES(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .byte_en(byte_en),
    .cpu_byte(cpu_byte), .byte_rdy(rdy16), .eq_wr_rst(wrst16), .eq_wr(wr16),
    .eq_gain_lsb(lsb16), .eq_gain_msb(msb16), .wr_addr_zero(zero16), .busy(busy16),
    .load_done(done16), .load_err(err16), .gain_count(cnt16)
  );

  // Gain-stage model: address clears on eq_wr_rst and advances on the delayed write strobe.
  logic [3:0] addr4 = 4'd0, addr16 = 4'd0;
  logic       wr4_d = 1'b0, wr16_d = 1'b0;
  logic       force4 = 1'b0, force16 = 1'b0;

  always @(posedge clk) begin
    wr4_d  <= wr4;
    wr16_d <= wr16;
    if (wrst4) addr4 <= 4'd0;
    else if (wr4_d) addr4 <= addr4 + 4'd1;
    if (wrst16) addr16 <= 4'd0;
    else if (wr16_d) addr16 <= addr16 + 4'd1;
  end

  assign zero4  = force4  ? 1'b1 : (addr4 == 4'd0);
  assign zero16 = force16 ? 1'b0 : (addr16 == 4'd0);

  int          nwr4 = 0, nwrst4 = 0, nwr16 = 0;
  logic [15:0] g4[$];
  logic [15:0] g16[$];

  always @(negedge clk) begin
    if (wr4) begin nwr4++; g4.push_back({msb4, lsb4}); end
    if (wrst4) nwrst4++;
    if (wr16) begin nwr16++; g16.push_back({msb16, lsb16}); end
  end

  logic [26:0] o4, o16;
  assign o4  = {rdy4, wrst4, wr4, busy4, done4, err4, cnt4, lsb4, msb4};
  assign o16 = {rdy16, wrst16, wr16, busy16, done16, err16, cnt16, lsb16, msb16};

  typedef struct {
    logic        ls;
    logic        be;
    logic [7:0]  b;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic ls, input logic be, input logic [7:0] b,
                              input logic rdy, input logic wrst, input logic wr, input logic bsy,
                              input logic dn, input logic er, input logic [4:0] cnt,
                              input logic [7:0] lsb, input logic [7:0] msb);
    vec_t v;
    v.ls  = ls;
    v.be  = be;
    v.b   = b;
    v.exp = {rdy, wrst, wr, bsy, dn, er, cnt, lsb, msb};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got no event expected one", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    int t = 0;
    while (!(sel ? rdy16 : rdy4) && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) bound_fail("byte_rdy_wait");
    byte_en  = 1'b1;
    cpu_byte = b;
    tick();
    byte_en  = 1'b0;
  endtask

  task automatic send_gain(input bit sel, input logic [15:0] g);
    send_byte(sel, g[7:0]);
    send_byte(sel, g[15:8]);
  endtask

  task automatic wait_done(input bit sel);
    int t = 0;
    while (!(sel ? done16 : done4) && t < 400) begin
      tick();
      t++;
    end
    if (t >= 400) bound_fail("load_done_wait");
  endtask

  logic [15:0] exp4[4];
  logic [15:0] rst_g[4];

  initial begin
    int base, base_rst, k;

    exp4  = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    rst_g = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};

    // Main load: inputs applied before each edge, registered outputs expected after it.
    vecs.push_back(mk(1, 1, 8'hFF, 0, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 8'h34, 1, 0, 0, 1, 0, 0, 0, 8'h34, 8'h00));
    vecs.push_back(mk(0, 1, 8'h12, 0, 0, 1, 1, 0, 0, 1, 8'h34, 8'h12));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 1, 8'h34, 8'h12));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 8'h34, 8'h12));
    vecs.push_back(mk(0, 1, 8'h78, 1, 0, 0, 1, 0, 0, 1, 8'h78, 8'h12));
    vecs.push_back(mk(0, 1, 8'h56, 0, 0, 1, 1, 0, 0, 2, 8'h78, 8'h56));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 2, 8'h78, 8'h56));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 2, 8'h78, 8'h56));
    vecs.push_back(mk(0, 1, 8'hBC, 1, 0, 0, 1, 0, 0, 2, 8'hBC, 8'h56));
    vecs.push_back(mk(0, 1, 8'h9A, 0, 0, 1, 1, 0, 0, 3, 8'hBC, 8'h9A));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 3, 8'hBC, 8'h9A));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 3, 8'hBC, 8'h9A));
    vecs.push_back(mk(0, 1, 8'hF0, 1, 0, 0, 1, 0, 0, 3, 8'hF0, 8'h9A));
    vecs.push_back(mk(0, 1, 8'hDE, 0, 0, 1, 1, 0, 0, 4, 8'hF0, 8'hDE));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 4, 8'hF0, 8'hDE));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 4, 8'hF0, 8'hDE));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 4, 8'hF0, 8'hDE));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 4, 8'hF0, 8'hDE));
    vecs.push_back(mk(0, 1, 8'h55, 0, 0, 0, 0, 0, 0, 4, 8'hF0, 8'hDE));

    repeat (2) tick();
    check("reset_out4", 32'(o4), 32'h0);
    check("reset_out16", 32'(o16), 32'h0);
    reset_n = 1'b1;
    tick();

    base = g4.size();
    for (int i = 0; i < vecs.size(); i++) begin
      load_start = vecs[i].ls;
      byte_en    = vecs[i].be;
      cpu_byte   = vecs[i].b;
      tick();
      check($sformatf("vec%0d", i), 32'(o4), 32'(vecs[i].exp));
    end
    load_start = 1'b0;
    byte_en    = 1'b0;
    check("main_wr_count", 32'(g4.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < g4.size()) check($sformatf("main_gain%0d", i), 32'(g4[base + i]), 32'(exp4[i]));

    // 16-gain load: address wraps to zero, which is the expected value.
    base = g16.size();
    pulse_start();
    for (int i = 0; i < 16; i++) send_gain(1'b1, {8'hA0 + 8'(i), 8'h10 + 8'(i)});
    wait_done(1'b1);
    check("g16_err", 32'(err16), 32'd0);
    check("g16_count", 32'(cnt16), 32'd16);
    check("g16_wr_count", 32'(g16.size() - base), 32'd16);
    for (int i = 0; i < 16; i++)
      if (base + i < g16.size())
        check($sformatf("g16_gain%0d", i), 32'(g16[base + i]), 32'({8'hA0 + 8'(i), 8'h10 + 8'(i)}));
    tick();

    // 16-gain load with the address-zero flag stuck low.
    force16 = 1'b1;
    pulse_start();
    for (int i = 0; i < 16; i++) send_gain(1'b1, 16'h0F0F);
    wait_done(1'b1);
    check("g16_mismatch_err", 32'(err16), 32'd1);
    force16 = 1'b0;
    tick();

    // 4-gain load with the address-zero flag stuck high.
    force4 = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) send_gain(1'b0, exp4[i]);
    wait_done(1'b0);
    check("g4_mismatch_err", 32'(err4), 32'd1);
    force4 = 1'b0;
    tick();

    // Overrun: a byte offered during WRITE is dropped and flagged.
    base = g4.size();
    pulse_start();
    check("start_clears_err", 32'(err4), 32'd0);
    send_gain(1'b0, exp4[0]);
    byte_en  = 1'b1;
    cpu_byte = 8'hEE;
    tick();
    byte_en  = 1'b0;
    check("overrun_err", 32'(err4), 32'd1);
    for (int i = 1; i < 4; i++) send_gain(1'b0, exp4[i]);
    wait_done(1'b0);
    check("overrun_err_sticky", 32'(err4), 32'd1);
    check("overrun_wr_count", 32'(g4.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < g4.size()) check($sformatf("overrun_gain%0d", i), 32'(g4[base + i]), 32'(exp4[i]));
    tick();

    // Restart after three bytes.
    base_rst = nwrst4;
    pulse_start();
    send_gain(1'b0, 16'h2211);
    send_byte(1'b0, 8'h33);
    pulse_start();
    check("restart_pulse", 32'({wrst4, cnt4}), 32'({1'b1, 5'd0}));
    base = g4.size();
    for (int i = 0; i < 4; i++) send_gain(1'b0, rst_g[i]);
    wait_done(1'b0);
    check("restart_err", 32'(err4), 32'd0);
    check("restart_wrst_count", 32'(nwrst4 - base_rst), 32'd2);
    check("restart_wr_count", 32'(g4.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < g4.size()) check($sformatf("restart_gain%0d", i), 32'(g4[base + i]), 32'(rst_g[i]));
    tick();

    // Asynchronous reset while waiting for the MSB byte.
    pulse_start();
    send_byte(1'b0, 8'h42);
    check("pre_reset_msb_state", 32'({rdy4, busy4}), 32'({1'b1, 1'b1}));
    base = nwr4;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_out4", 32'(o4), 32'h0);
    check("async_reset_out16", 32'(o16), 32'h0);
    tick();
    reset_n = 1'b1;
    byte_en  = 1'b1;
    cpu_byte = 8'h99;
    repeat (2) tick();
    byte_en = 1'b0;
    repeat (8) tick();
    check("post_reset_no_wr", 32'(nwr4 - base), 32'd0);
    check("post_reset_idle", 32'({busy4, err4}), 32'd0);

`ifdef EQ_LOAD_TIMEOUT_EN
    // Stall after one byte: the load aborts after 16 idle cycles with no write.
    base = nwr4;
    pulse_start();
    send_byte(1'b0, 8'h11);
    k = 0;
    while (!done4 && k < 40) begin
      tick();
      k++;
    end
    check("timeout_cycles", 32'(k), 32'd16);
    check("timeout_err", 32'(err4), 32'd1);
    check("timeout_no_wr", 32'(nwr4 - base), 32'd0);
    tick();
    check("timeout_idle", 32'(busy4), 32'd0);
`else
    k = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
